// File: rtl/mem_write_sched_if.sv
// mem_write_sched_if: host fill, core store and memory write-port signals.
interface mem_write_sched_if #(
    parameter int LANES      = 4,
    parameter int MEM_DEPTH  = 24,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int LEN_WIDTH  = ADDR_WIDTH + $clog2(LANES) + 1
);
    logic                                host_start;
    logic [ADDR_WIDTH-1:0]               host_base;
    logic [LEN_WIDTH-1:0]                host_len;
    logic                                host_valid;
    logic [DATA_WIDTH-1:0]               host_data;
    logic                                host_ready;
    logic                                host_busy;
    logic                                host_done;
    logic                                host_err;
    logic                                core_valid;
    logic [LANES-1:0]                    core_mask;
    logic [LANES-1:0][ADDR_WIDTH-1:0]    core_addr;
    logic [LANES-1:0][DATA_WIDTH-1:0]    core_data;
    logic                                core_ready;
    logic                                core_err;
    logic [LANES-1:0]                    mem_write_en;
    logic [LANES-1:0][ADDR_WIDTH-1:0]    mem_write_addr;
    logic [LANES-1:0][DATA_WIDTH-1:0]    mem_write_data;
    modport master (
        output host_start, host_base, host_len, host_valid, host_data,
        output core_valid, core_mask, core_addr, core_data,
        input  host_ready, host_busy, host_done, host_err, core_ready, core_err,
        input  mem_write_en, mem_write_addr, mem_write_data
    );
    modport slave (
        input  host_start, host_base, host_len, host_valid, host_data,
        input  core_valid, core_mask, core_addr, core_data,
        output host_ready, host_busy, host_done, host_err, core_ready, core_err,
        output mem_write_en, mem_write_addr, mem_write_data
    );
endinterface

// File: rtl/mem_write_sched.sv
// mem_write_sched: shares the per-lane memory write port between host bulk fill and core stores.
// Fills are sequenced by an IDLE/FILL/DONE FSM; contested cycles arbitrate round-robin.
module mem_write_sched #(
    parameter int LANES      = 4,
    parameter int MEM_DEPTH  = 24,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int LEN_WIDTH  = ADDR_WIDTH + $clog2(LANES) + 1
) (
    input logic clk,
    input logic rst,
    mem_write_sched_if.slave bus
);
    localparam int LG = $clog2(LANES);
    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;
    state_t                            r_state, w_next;
    logic [ADDR_WIDTH-1:0]             r_base;
    logic [LEN_WIDTH-1:0]              r_len, r_k;
    logic                              r_rr;
    logic                              r_err, r_core_err;
    logic [LANES-1:0]                  r_we;
    logic [LANES-1:0][ADDR_WIDTH-1:0]  r_waddr;
    logic [LANES-1:0][DATA_WIDTH-1:0]  r_wdata;
    logic                              w_fill, w_host_ready, w_core_ready, w_host_hs, w_core_hs;
    logic                              w_last, w_zero, w_oor;
    logic [LEN_WIDTH:0]                w_words, w_end;
    logic [LANES-1:0]                  w_in_range, w_host_lane;
    logic [ADDR_WIDTH-1:0]             w_host_addr;
    // Start checks: rows needed per lane is ceil(len/lanes), rounded up via shift.
    assign w_zero      = bus.host_len == '0;
    assign w_words     = ({1'b0, bus.host_len} + (LEN_WIDTH+1)'(LANES-1)) >> LG;
    assign w_end       = w_words + (LEN_WIDTH+1)'(bus.host_base);
    assign w_oor       = w_end > (LEN_WIDTH+1)'(MEM_DEPTH);
    assign w_last      = r_k == r_len - LEN_WIDTH'(1);
    assign w_host_addr = r_base + ADDR_WIDTH'(r_k >> LG);
    assign w_host_lane = LANES'(1) << r_k[LG-1:0];
    assign w_host_hs   = bus.host_valid && w_host_ready;
    assign w_core_hs   = bus.core_valid && w_core_ready;
    always_comb begin
        for (int i = 0; i < LANES; i++)
            w_in_range[i] = {1'b0, bus.core_addr[i]} < (ADDR_WIDTH+1)'(MEM_DEPTH);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next = (r_state == S_IDLE) ? (bus.host_start ? ((w_zero || w_oor) ? S_DONE : S_FILL) : S_IDLE) :
                 (r_state == S_FILL) ? ((w_host_hs && w_last) ? S_DONE : S_FILL) : S_IDLE;
    end
    // r_rr: 0 grants the core on a contested cycle, 1 grants the host.
    always_comb begin
        w_fill        = r_state == S_FILL;
        w_host_ready  = w_fill && (!bus.core_valid || r_rr);
        w_core_ready  = !rst && (!w_fill || !bus.host_valid || !r_rr);
        bus.host_ready = w_host_ready;
        bus.core_ready = w_core_ready;
        bus.host_busy  = w_fill;
        bus.host_done  = r_state == S_DONE;
        bus.host_err   = r_err;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base     <= '0;
            r_len      <= '0;
            r_k        <= '0;
            r_rr       <= 1'b0;
            r_err      <= 1'b0;
            r_we       <= '0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_core_err <= 1'b0;
        end else begin
            if (r_state == S_IDLE && bus.host_start) begin
                r_base <= bus.host_base;
                r_len  <= bus.host_len;
                r_k    <= '0;
                if (!w_zero) r_err <= w_oor;
            end else if (w_host_hs) begin
                r_k <= r_k + LEN_WIDTH'(1);
            end
            if (w_fill && bus.host_valid && bus.core_valid) r_rr <= !r_rr;
            r_we       <= w_host_hs ? w_host_lane : (w_core_hs ? (bus.core_mask & w_in_range) : '0);
            r_core_err <= w_core_hs && |(bus.core_mask & ~w_in_range);
            if (w_host_hs) begin
                r_waddr <= {LANES{w_host_addr}};
                r_wdata <= {LANES{bus.host_data}};
            end else if (w_core_hs) begin
                r_waddr <= bus.core_addr;
                r_wdata <= bus.core_data;
            end
        end
    end
    assign bus.mem_write_en   = r_we;
    assign bus.mem_write_addr = r_waddr;
    assign bus.mem_write_data = r_wdata;
    assign bus.core_err       = r_core_err;
endmodule

// File: tb/tb_mem_write_sched.sv
// tb_mem_write_sched: randomized and directed checks of mem_write_sched against a behavioural model.
module tb_mem_write_sched;
    localparam int L  = 4;
    localparam int D  = 24;
    localparam int DW = 16;
    localparam int AW = $clog2(D);
    localparam int LW = AW + $clog2(L) + 1;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    mem_write_sched_if #(.LANES(L), .MEM_DEPTH(D), .DATA_WIDTH(DW)) bus ();
    mem_write_sched #(.LANES(L), .MEM_DEPTH(D), .DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));
    int checks = 0;
    int errors = 0;
    // Model: fill phase 0 idle, 1 fill, 2 done; pending write mirrors the one-cycle port latency.
    int              m_st, m_base, m_len, m_k;
    bit              m_pref_host, m_err;
    logic [L-1:0]    e_we;
    bit              e_cerr;
    logic [AW-1:0]   e_addr [L];
    logic [DW-1:0]   e_data [L];
    logic [DW-1:0]   exp_mem [L][D];
    logic [DW-1:0]   dut_mem [L][D];
    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    always @(posedge clk)
        if (!rst)
            for (int i = 0; i < L; i++)
                if (bus.mem_write_en[i]) dut_mem[i][bus.mem_write_addr[i]] <= bus.mem_write_data[i];
    task automatic idle();
        bus.host_start = 0; bus.host_base = '0; bus.host_len = '0;
        bus.host_valid = 0; bus.host_data = '0;
        bus.core_valid = 0; bus.core_mask = '0; bus.core_addr = '0; bus.core_data = '0;
    endtask
    task automatic rand_core();
        bus.core_valid = 1'($urandom);
        bus.core_mask  = L'($urandom);
        for (int i = 0; i < L; i++) begin
            bus.core_addr[i] = ($urandom % 5 == 0) ? AW'($urandom_range(D, 2**AW - 1)) : AW'($urandom_range(0, D - 1));
            bus.core_data[i] = DW'($urandom);
        end
    endtask
    task automatic model_reset();
        m_st = 0; m_k = 0; m_pref_host = 0; m_err = 0; e_we = '0; e_cerr = 0;
    endtask
    task automatic step();
        logic hr, cr, hh, ch;
        logic [L-1:0] nwe;
        bit ncerr;
        int lane, words;
        #1;
        check("busy", bus.host_busy, m_st == 1);
        check("done", bus.host_done, m_st == 2);
        check("err", bus.host_err, m_err);
        if (m_st != 1) begin hr = 0; cr = 1; end
        else if (bus.host_valid && bus.core_valid) begin hr = m_pref_host; cr = !m_pref_host; end
        else begin hr = bus.host_valid; cr = bus.core_valid; end
        if (m_st != 1 || bus.host_valid) check("host_ready", bus.host_ready, hr);
        if (m_st != 1 || bus.core_valid) check("core_ready", bus.core_ready, cr);
        hh = bus.host_valid && hr;
        ch = bus.core_valid && cr;
        for (int i = 0; i < L; i++) if (e_we[i]) exp_mem[i][e_addr[i]] = e_data[i];
        nwe = '0; ncerr = 0;
        if (hh) begin
            lane = m_k % L;
            e_addr[lane] = AW'(m_base + m_k / L);
            e_data[lane] = bus.host_data;
            nwe[lane] = 1;
            m_k++;
        end else if (ch) begin
            for (int i = 0; i < L; i++)
                if (bus.core_mask[i]) begin
                    if (int'(bus.core_addr[i]) < D) begin
                        nwe[i] = 1; e_addr[i] = bus.core_addr[i]; e_data[i] = bus.core_data[i];
                    end else ncerr = 1;
                end
        end
        if (m_st == 1 && bus.host_valid && bus.core_valid) m_pref_host = !m_pref_host;
        if (m_st == 0) begin
            if (bus.host_start) begin
                words = (int'(bus.host_len) + L - 1) / L;
                if (bus.host_len == 0) m_st = 2;
                else if (int'(bus.host_base) + words > D) begin m_err = 1; m_st = 2; end
                else begin
                    m_err = 0; m_base = int'(bus.host_base); m_len = int'(bus.host_len); m_k = 0; m_st = 1;
                end
            end
        end else if (m_st == 1) begin
            if (hh && m_k == m_len) m_st = 2;
        end else m_st = 0;
        e_we = nwe; e_cerr = ncerr;
        @(posedge clk);
        @(negedge clk);
        check("write_en", bus.mem_write_en, e_we);
        check("core_err", bus.core_err, e_cerr);
        for (int i = 0; i < L; i++)
            if (e_we[i]) begin
                check("write_addr", bus.mem_write_addr[i], e_addr[i]);
                check("write_data", bus.mem_write_data[i], e_data[i]);
            end
    endtask
    task automatic start_fill(int base, int len);
        bus.host_start = 1; bus.host_base = AW'(base); bus.host_len = LW'(len);
        step();
        bus.host_start = 0;
    endtask
    task automatic run_to_idle(string tag);
        for (int c = 0; c < 300 && m_st != 0; c++) step();
        check(tag, bus.host_busy, 0);
    endtask
    initial begin
        for (int i = 0; i < L; i++)
            for (int a = 0; a < D; a++) begin exp_mem[i][a] = '0; dut_mem[i][a] = '0; end
        idle();
        model_reset();
        rst = 1;
        #3;
        check("rst_we", bus.mem_write_en, 0);
        check("rst_addr", bus.mem_write_addr, 0);
        check("rst_core_ready", bus.core_ready, 0);
        check("rst_done", bus.host_done, 0);
        repeat (2) @(negedge clk);
        rst = 0;
        // Directed: single-stream fill, base 10, six words.
        bus.host_valid = 1; bus.host_data = DW'($urandom);
        start_fill(10, 6);
        for (int c = 0; c < 30 && m_st != 0; c++) begin bus.host_data = DW'($urandom); step(); end
        check("t1_idle", bus.host_busy, 0);
        // Directed: both requesters held valid, grants must alternate starting with core.
        bus.host_valid = 1;
        start_fill(0, 8);
        bus.core_valid = 1; bus.core_mask = '1;
        for (int c = 0; c < 40 && m_st != 0; c++) begin
            bus.host_data = DW'($urandom);
            for (int i = 0; i < L; i++) begin bus.core_addr[i] = AW'($urandom_range(0, D - 1)); bus.core_data[i] = DW'($urandom); end
            step();
        end
        check("t2_idle", bus.host_busy, 0);
        idle();
        // Directed: range fault at the top of memory.
        start_fill(D - 1, L + 1);
        step();
        check("t3_err", bus.host_err, 1);
        step();
        // Directed: masked core store with one lane out of range.
        bus.core_valid = 1; bus.core_mask = 4'b1011;
        for (int i = 0; i < L; i++) begin bus.core_addr[i] = AW'(i + 3); bus.core_data[i] = DW'($urandom); end
        bus.core_addr[1] = AW'(D);
        step();
        check("t4_we", bus.mem_write_en, 4'b1001);
        check("t4_err", bus.core_err, 1);
        idle();
        // Directed: zero-length start, then a start pulse during FILL must be ignored.
        start_fill(3, 0);
        step();
        bus.host_valid = 1;
        start_fill(2, 7);
        bus.host_start = 1; bus.host_base = AW'(20); bus.host_len = LW'(1);
        step();
        bus.host_start = 0;
        run_to_idle("t6_idle");
        idle();
        // Directed: async reset after three of eight words.
        bus.host_valid = 1;
        start_fill(5, 8);
        repeat (3) begin bus.host_data = DW'($urandom); step(); end
        #2 rst = 1;
        #1;
        check("t5_we", bus.mem_write_en, 0);
        check("t5_addr", bus.mem_write_addr, 0);
        check("t5_data", bus.mem_write_data, 0);
        check("t5_busy", bus.host_busy, 0);
        check("t5_ready", bus.host_ready, 0);
        check("t5_done", bus.host_done, 0);
        model_reset();
        @(negedge clk);
        rst = 0;
        start_fill(1, 5);
        run_to_idle("t5_refill");
        // Random fills with random core traffic and stray start pulses.
        for (int n = 0; n < 25; n++) begin
            bus.host_start = 1;
            bus.host_base = AW'($urandom_range(0, D - 1));
            bus.host_len  = LW'($urandom_range(0, 40));
            bus.host_valid = 1'($urandom); bus.host_data = DW'($urandom);
            rand_core();
            step();
            for (int c = 0; c < 300 && m_st != 0; c++) begin
                bus.host_start = ($urandom % 8 == 0);
                bus.host_valid = 1'($urandom); bus.host_data = DW'($urandom);
                rand_core();
                step();
            end
            check("rand_idle", bus.host_busy, 0);
            bus.host_start = 0;
            for (int c = 0; c < 3; c++) begin rand_core(); step(); end
        end
        idle();
        repeat (2) step();
        for (int i = 0; i < L; i++)
            for (int a = 0; a < D; a++) check("memory", dut_mem[i][a], exp_mem[i][a]);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
